// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with sign fixup and fast paths for divide corner cases.
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            kill_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2:0]          op_q;
   logic                neg_q;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [2*XLEN-1:0]   acc_d;
   logic [XLEN-1:0]     b_q;
   logic [XLEN-1:0]     result_q;

   logic                sgn1;
   logic                sgn2;
   logic                a_neg;
   logic                b_neg;
   logic                is_div;
   logic                div0;
   logic                ovf;
   logic                neg_in;
   logic [XLEN-1:0]     a_mag;
   logic [XLEN-1:0]     b_mag;
   logic [XLEN-1:0]     spec_res;

   always_comb begin
      is_div   = funct3_i[2];
      sgn2     = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                 (funct3_i == 3'b110);
      sgn1     = sgn2 || (funct3_i == 3'b010);
      a_neg    = sgn1 & rs1_i[XLEN-1];
      b_neg    = sgn2 & rs2_i[XLEN-1];
      a_mag    = a_neg ? -rs1_i : rs1_i;
      b_mag    = b_neg ? -rs2_i : rs2_i;
      // remainder follows the dividend sign, everything else the xor
      neg_in   = (funct3_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
      div0     = is_div && (rs2_i == '0);
      ovf      = is_div && !funct3_i[0] &&
                 (rs1_i == MIN_NEG) && (rs2_i == '1);
      spec_res = funct3_i[1] ? (div0 ? rs1_i : '0)
                             : (div0 ? '1 : rs1_i);
   end

   logic [XLEN:0] msum;
   logic [XLEN:0] dtrial;

   always_comb begin
      msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, b_q} : '0);
      dtrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
      if (op_q[2]) begin
         acc_d = dtrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_d = {msum, acc_q[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   part;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      prod_s  = neg_q ? -acc_q : acc_q;
      part    = '0;
      fix_res = '0;
      if (op_q[2]) begin
         part    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
         fix_res = neg_q ? -part : part;
      end else begin
         fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                        : prod_s[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else if (kill_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_q    <= funct3_i;
                  neg_q   <= neg_in;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  // divide shifts the dividend out of the low half,
                  // multiply shifts the multiplier out of it
                  acc_q   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                  b_q     <= is_div ? b_mag : a_mag;
                  if (div0 || ovf) begin
                     result_q <= spec_res;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) state_q <= FIXUP;
            end
            FIXUP: begin
               result_q <= fix_res;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: one XLEN=32 and one XLEN=8 instance,
// directed spec vectors plus random ops against a 64-bit arithmetic model.
module tb_mul_div_unit;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          stamp;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start [2];
   logic        kill  [2];
   logic [2:0]  f3    [2];
   logic [31:0] a     [2];
   logic [31:0] b     [2];
   logic        rdy   [2];
   logic        bsy   [2];
   logic        dn    [2];
   logic [31:0] res   [2];

   logic        r0, r1, b0, b1, d0, d1;
   logic [31:0] res0;
   logic [7:0]  res8;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   exp_t q0[$];
   exp_t q1[$];

   mul_div_unit #(.XLEN(32)) u32 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start[0]), .funct3_i(f3[0]),
      .rs1_i(a[0]), .rs2_i(b[0]), .kill_i(kill[0]),
      .ready_o(r0), .busy_o(b0), .done_o(d0), .result_o(res0)
   );

   mul_div_unit #(.XLEN(8)) u8 (
      .clk_i(clk), .rst_i(rst_n), .start_i(start[1]), .funct3_i(f3[1]),
      .rs1_i(a[1][7:0]), .rs2_i(b[1][7:0]), .kill_i(kill[1]),
      .ready_o(r1), .busy_o(b1), .done_o(d1), .result_o(res8)
   );

   assign rdy[0] = r0;
   assign rdy[1] = r1;
   assign bsy[0] = b0;
   assign bsy[1] = b1;
   assign dn[0]  = d0;
   assign dn[1]  = d1;
   assign res[0] = res0;
   assign res[1] = {24'd0, res8};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic longint mask_of(int xl);
      return (longint'(1) << xl) - 1;
   endfunction

   // Reference: plain signed/unsigned 64-bit arithmetic per RV32M rules
   function automatic logic [31:0] ref_op(int xl, logic [2:0] f,
                                          logic [31:0] x, logic [31:0] y);
      longint m, ua, ub, sa, sb, r;
      longint unsigned uu;
      m  = mask_of(xl);
      ua = longint'(x) & m;
      ub = longint'(y) & m;
      sa = x[xl-1] ? ua - (longint'(1) << xl) : ua;
      sb = y[xl-1] ? ub - (longint'(1) << xl) : ub;
      case (f)
         3'b000: r = (sa * sb) & m;
         3'b001: r = ((sa * sb) >>> xl) & m;
         3'b010: r = ((sa * ub) >>> xl) & m;
         3'b011: begin
            uu = longint'(ua) * longint'(ub);
            r  = longint'(uu >> xl) & m;
         end
         3'b100: r = (ub == 0) ? m :
                     (sa == -(longint'(1) << (xl-1)) && sb == -1) ? ua :
                     (sa / sb) & m;
         3'b101: r = (ub == 0) ? m : ua / ub;
         3'b110: r = (ub == 0) ? ua :
                     (sa == -(longint'(1) << (xl-1)) && sb == -1) ? 0 :
                     (sa % sb) & m;
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r);
   endfunction

   function automatic bit is_fast(int xl, logic [2:0] f,
                                  logic [31:0] x, logic [31:0] y);
      longint m;
      m = mask_of(xl);
      if (!f[2]) return 1'b0;
      if ((longint'(y) & m) == 0) return 1'b1;
      return !f[0] && ((longint'(x) & m) == (longint'(1) << (xl-1))) &&
             ((longint'(y) & m) == m);
   endfunction

   function automatic logic [31:0] gen(int xl);
      logic [31:0] m;
      m = 32'(mask_of(xl));
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return m;
         2: return 32'd1 << (xl-1);
         3: return 32'd1;
         default: return $urandom & m;
      endcase
   endfunction

   task automatic issue(int d, logic [2:0] f, logic [31:0] x,
                        logic [31:0] y, logic [31:0] want, int lat);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!rdy[d] && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!rdy[d]) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      start[d] = 1'b1;
      f3[d]    = f;
      a[d]     = x;
      b[d]     = y;
      e.res    = want;
      e.lat    = lat;
      e.stamp  = cyc;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(negedge clk);
      start[d] = 1'b0;
      a[d]     = $urandom;
      b[d]     = $urandom;
   endtask

   task automatic rand_run(int d, int n);
      int xl;
      logic [2:0]  f;
      logic [31:0] x, y;
      xl = (d == 0) ? 32 : 8;
      repeat (n) begin
         f = 3'($urandom_range(0, 7));
         x = gen(xl);
         y = gen(xl);
         if (f[2] && $urandom_range(0, 9) == 0) begin
            x = 32'd1 << (xl-1);
            y = 32'(mask_of(xl));
         end
         issue(d, f, x, y, ref_op(xl, f, x, y),
               is_fast(xl, f, x, y) ? 1 : xl + 2);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (dn[d]) begin
            exp_t e;
            bit   have;
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin
               e = q0.pop_front();
               have = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
               e = q1.pop_front();
               have = 1'b1;
            end
            if (!have) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               chk(d == 0 ? "result32" : "result8", res[d], e.res);
               chk(d == 0 ? "latency32" : "latency8",
                   32'(cyc - e.stamp), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      logic [31:0] hold;
      int n;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0;
         kill[d]  = 1'b0;
         f3[d]    = 3'd0;
         a[d]     = 32'd0;
         b[d]     = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", 32'(rdy[d]), 32'd1);
         chk("rst_busy", 32'(bsy[d]), 32'd0);
         chk("rst_done", 32'(dn[d]), 32'd0);
         chk("rst_result", res[d], 32'd0);
      end
      rst_n = 1'b1;

      issue(0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      issue(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34);
      issue(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      issue(0, 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
      issue(0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
      issue(0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
      issue(0, 3'b101, 32'd100, 32'd7, 32'd14, 34);
      issue(0, 3'b111, 32'd100, 32'd7, 32'd2, 34);
      issue(0, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      issue(0, 3'b110, 32'd5, 32'd0, 32'd5, 1);
      issue(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      issue(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

      // kill in the middle of CALC
      issue(0, 3'b000, 32'd9, 32'd9, 32'd81, 34);
      hold = 32'd0;
      repeat (9) @(negedge clk);
      kill[0] = 1'b1;
      @(negedge clk);
      kill[0] = 1'b0;
      hold = res[0];
      chk("kill_ready", 32'(rdy[0]), 32'd1);
      chk("kill_busy", 32'(bsy[0]), 32'd0);
      chk("kill_result", hold, 32'd0);
      void'(q0.pop_back());

      // start while busy is ignored
      issue(0, 3'b101, 32'd100, 32'd7, 32'd14, 34);
      repeat (5) begin
         start[0] = 1'b1;
         f3[0]    = 3'b000;
         a[0]     = 32'd5;
         b[0]     = 32'd5;
         @(negedge clk);
      end
      start[0] = 1'b0;

      // kill together with start in IDLE rejects the start
      n = 0;
      while (!rdy[0] && n < 100) begin
         n++;
         @(negedge clk);
      end
      start[0] = 1'b1;
      kill[0]  = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      kill[0]  = 1'b0;
      chk("killstart_ready", 32'(rdy[0]), 32'd1);
      chk("killstart_busy", 32'(bsy[0]), 32'd0);

      // asynchronous reset during CALC
      issue(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", 32'(rdy[0]), 32'd1);
      chk("arst_busy", 32'(bsy[0]), 32'd0);
      chk("arst_done", 32'(dn[0]), 32'd0);
      chk("arst_result", res[0], 32'd0);
      void'(q0.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);

      fork
         rand_run(0, 500);
         rand_run(1, 2000);
      join

      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 32'(q0.size() + q1.size()), 32'd0);
      repeat (50) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
